// File: rtl/div_clock_monitor_pkg.sv
// clkmon_pkg: shared types and helpers for the divided-clock monitors.
// Holds the FSM state enum, select codes and expected-period lookup.
package clkmon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    LOCKED,
    STOPPED
  } state_t;

  localparam logic [1:0] SEL_DIV2 = 2'd0;
  localparam logic [1:0] SEL_DIV4 = 2'd1;
  localparam logic [1:0] SEL_DIV8 = 2'd2;
  localparam logic [1:0] SEL_OFF  = 2'd3;

  // Expected rise-to-rise period; 0 when the divider is held low.
  function automatic logic [3:0] exp_period(input logic [1:0] sel);
    logic [3:0] p;
    p = 4'd0;
    unique case (1'b1)
      sel == SEL_DIV2: p = 4'd2;
      sel == SEL_DIV4: p = 4'd4;
      sel == SEL_DIV8: p = 4'd8;
      default:         p = 4'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/div_clock_monitor_if.sv
// div_clock_monitor_if: select/divider inputs and status outputs.
// master drives sel, div_in, err_clr; slave returns period and status.
interface div_clock_monitor_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       sel;
  logic             div_in;
  logic             err_clr;
  logic [CNT_W-1:0] period;
  logic             meas_valid;
  logic             locked;
  logic             err;

  modport master (
    output sel, div_in, err_clr,
    input  period, meas_valid, locked, err
  );

  modport slave (
    input  sel, div_in, err_clr,
    output period, meas_valid, locked, err
  );
endinterface

// File: rtl/div_clock_monitor_edge_det.sv
// clkmon_edge_det: registers d and flags a rising edge.
// Ports: clk, rst (sync, active high), d in, rise out (comb).
module clkmon_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/div_clock_monitor.sv
// div_clock_monitor: checks divider output period against sel.
// Ports: clk, rst (sync, active high), bus (slave: sel/div_in/err_clr in,
//   period/meas_valid/locked/err out).
module div_clock_monitor
  import clkmon_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 4
) (
  input logic              clk,
  input logic              rst,
  div_clock_monitor_if.slave bus
);
  localparam int MW = $clog2(LOCK_N + 1);
  localparam logic [MW-1:0] MCNT_LOCK = MW'(LOCK_N);

  state_t state, state_d;

  logic             rise;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] cnt, cnt_d, exp_c;
  logic [CNT_W-1:0] period_q, period_d;
  logic [MW-1:0]    mcnt, mcnt_d, mcnt_inc;
  logic             mv_q, mv_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d, err_set;
  logic             sel_chg, match, tmo;

  clkmon_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.div_in),
    .rise (rise)
  );

  assign exp_c    = CNT_W'(exp_period(bus.sel));
  assign sel_chg  = bus.sel != sel_q;
  assign match    = rise && (cnt == exp_c);
  // A due edge that did not arrive: fires one cycle after it was expected.
  assign tmo      = !rise && (cnt == exp_c);
  assign mcnt_inc = mcnt + 1'b1;
  assign cnt_d    = rise ? CNT_W'(1) : (&cnt ? cnt : cnt + 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= 2'd0;
      cnt      <= '0;
      mcnt     <= '0;
      period_q <= '0;
      mv_q     <= 1'b0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_d;
      sel_q    <= bus.sel;
      cnt      <= cnt_d;
      mcnt     <= mcnt_d;
      period_q <= period_d;
      mv_q     <= mv_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    if (sel_chg) begin
      state_d = (bus.sel == SEL_OFF) ? STOPPED : IDLE;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (rise) state_d = ARM;
        end
        state == ARM: begin
          if (match && mcnt_inc == MCNT_LOCK) state_d = LOCKED;
          else if (tmo)                       state_d = IDLE;
        end
        state == LOCKED: begin
          if (rise && !match) state_d = ARM;
          else if (tmo)       state_d = IDLE;
        end
        default: state_d = state;
      endcase
    end
  end

  always_comb begin
    mcnt_d   = mcnt;
    period_d = period_q;
    mv_d     = 1'b0;
    lock_d   = lock_q;
    err_set  = 1'b0;
    if (sel_chg) begin
      mcnt_d = '0;
      lock_d = 1'b0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          lock_d = 1'b0;
        end
        state == ARM: begin
          if (rise) begin
            period_d = cnt;
            mv_d     = 1'b1;
            mcnt_d   = match ? mcnt_inc : '0;
            lock_d   = match && (mcnt_inc == MCNT_LOCK);
          end else if (tmo) begin
            mcnt_d = '0;
            lock_d = 1'b0;
          end
        end
        state == LOCKED: begin
          if (rise) begin
            period_d = cnt;
            mv_d     = 1'b1;
            if (!match) begin
              err_set = 1'b1;
              lock_d  = 1'b0;
              mcnt_d  = '0;
            end
          end else if (tmo) begin
            err_set = 1'b1;
            lock_d  = 1'b0;
            mcnt_d  = '0;
          end
        end
        default: begin
          lock_d  = 1'b0;
          err_set = rise;
        end
      endcase
    end
    // Set beats clear when both land in the same cycle.
    err_d = err_set | (err_q & ~bus.err_clr);
  end

  assign bus.period     = period_q;
  assign bus.meas_valid = mv_q;
  assign bus.locked     = lock_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_div_clock_monitor.sv
// tb_div_clock_monitor: segment-table and hand-written sequences for
// div_clock_monitor with a per-cycle expected-output scoreboard.
module tb_div_clock_monitor;
  import clkmon_pkg::*;

  localparam int CNT_W  = 8;
  localparam int LOCK_N = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_clock_monitor_if #(.CNT_W(CNT_W)) bus ();

  div_clock_monitor #(
    .CNT_W  (CNT_W),
    .LOCK_N (LOCK_N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic             mv;
    logic [CNT_W-1:0] per;
    logic             lk;
    logic             er;
  } exp_t;

  // One segment: n periods of length per; rise i opens period i.
  typedef struct {
    logic [1:0] sel;
    int         per;
    int         n;
    bit         clr;
    int         fp;
    int         mv_from;
    int         lock_from;
    bit         e_err;
  } seg_t;

  exp_t             sbq[$];
  seg_t             segs[8];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc_no = 0;
  logic [CNT_W-1:0] ep;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0d want %0d", nm, cyc_no, act, req);
    end
  endtask

  task automatic cyc(input logic r, input logic [1:0] s, input logic d,
                     input logic c, input logic mv, input logic lk,
                     input logic er);
    exp_t e;
    @(negedge clk);
    rst         = r;
    bus.sel     = s;
    bus.div_in  = d;
    bus.err_clr = c;
    e.mv  = mv;
    e.per = ep;
    e.lk  = lk;
    e.er  = er;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    cyc_no++;
    e = sbq.pop_front();
    chk("meas_valid", int'(bus.meas_valid), int'(e.mv));
    chk("period", int'(bus.period), int'(e.per));
    chk("locked", int'(bus.locked), int'(e.lk));
    chk("err", int'(bus.err), int'(e.er));
  endtask

  task automatic run_seg(input seg_t g);
    for (int i = 1; i <= g.n; i++) begin
      for (int j = 0; j < g.per; j++) begin
        logic mv;
        logic d;
        mv = (j == 0) && (i >= g.mv_from);
        d  = (j < (g.per + 1) / 2);
        if (mv) ep = (i == 1) ? CNT_W'(g.fp) : CNT_W'(g.per);
        cyc(1'b0, g.sel, d, g.clr && i == 1 && j == 0,
            mv, i >= g.lock_from, g.e_err);
      end
    end
  endtask

  initial begin
    //          sel  per n  clr fp mv lk err
    segs[0] = '{2'd0, 2, 8, 1'b0, 2, 2, 5, 1'b0};
    segs[1] = '{2'd2, 8, 6, 1'b0, 8, 2, 5, 1'b0};
    segs[2] = '{2'd1, 4, 6, 1'b0, 4, 2, 5, 1'b0};
    segs[3] = '{2'd1, 3, 1, 1'b0, 4, 1, 0, 1'b0};
    segs[4] = '{2'd1, 4, 5, 1'b1, 3, 1, 5, 1'b1};
    segs[5] = '{2'd1, 4, 2, 1'b1, 4, 1, 0, 1'b0};
    segs[6] = '{2'd1, 4, 5, 1'b1, 4, 1, 4, 1'b0};
    segs[7] = '{2'd1, 4, 5, 1'b0, 4, 2, 5, 1'b0};

    rst         = 1'b1;
    bus.sel     = 2'd0;
    bus.div_in  = 1'b0;
    bus.err_clr = 1'b0;
    ep          = '0;

    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd0, i[0], 1'b0, 0, 0, 0);

    // Lock at /2.
    run_seg(segs[0]);

    // Select change while locked, relock at /8.
    cyc(1'b0, 2'd2, 1'b0, 1'b0, 0, 0, 0);
    run_seg(segs[1]);

    // Held-low select: an edge is an error; then clear and go to /4.
    cyc(1'b0, 2'd3, 1'b0, 1'b0, 0, 0, 0);
    cyc(1'b0, 2'd3, 1'b1, 1'b0, 0, 0, 1);
    cyc(1'b0, 2'd3, 1'b0, 1'b0, 0, 0, 1);
    cyc(1'b0, 2'd3, 1'b0, 1'b1, 0, 0, 0);
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 0, 0, 0);

    // Lock at /4, short period, early edge with clear colliding.
    run_seg(segs[2]);
    run_seg(segs[3]);
    run_seg(segs[4]);

    // Clear alone while locked.
    run_seg(segs[5]);

    // Timeout: div_in stuck low, then reference edge gives no measure.
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 0, 0, 1);
    cyc(1'b0, 2'd1, 1'b1, 1'b0, 0, 0, 1);
    cyc(1'b0, 2'd1, 1'b1, 1'b0, 0, 0, 1);
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 0, 0, 1);
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 0, 0, 1);
    run_seg(segs[6]);

    // Reset mid-period while locked, then relock from IDLE.
    cyc(1'b0, 2'd1, 1'b1, 1'b0, 1, 1, 0);
    ep = '0;
    cyc(1'b1, 2'd1, 1'b1, 1'b0, 0, 0, 0);
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 0, 0, 0);
    run_seg(segs[7]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/div_clock_monitor.md
# div_clock_monitor

Checks the divided clock from the /2, /4, /8 frequency divider against its select code. Sits directly downstream of the divider in the same `clk` domain. Samples the divided output every `clk` cycle and measures the rising-edge-to-rising-edge period. Reports lock after consecutive correct periods and raises a sticky error on any deviation once locked.

## Interface
- `CNT_W`, default 8: period counter width; saturates at 2^CNT_W-1.
- `LOCK_N`, default 4: consecutive matching periods required to assert `locked`.

- `clk`  in  1  single clock shared with the divider.
- `rst`  in  1  synchronous, active-high reset.
- `sel`  in  2  divider select as driven to the divider (0:/2, 1:/4, 2:/8, 3:output held low).
- `div_in`  in  1  divider output; synchronous to `clk`, no synchronizer.
- `err_clr`  in  1  one-cycle pulse that clears `err`.
- `period`  out  CNT_W  last measured period in `clk` cycles.
- `meas_valid`  out  1  one-cycle pulse when `period` updates.
- `locked`  out  1  divider output matches `sel`.
- `err`  out  1  sticky; a mismatch occurred while locked, or an edge occurred while `sel`=3.

## Operation
- **Edge detection:** `div_q` registers `div_in`. `rise = div_in & ~div_q`.
- **Period counter `cnt`:** loads 1 on `rise`, otherwise increments, saturating at 2^CNT_W-1.
- **Expected period:** `exp` = 2, 4, 8 for `sel` = 0, 1, 2.
- **Match counter `mcnt`:** 0..LOCK_N.
- **Select-change detect:** `sel_q` registers `sel`. `sel != sel_q` is a select change.
- **FSM states:** IDLE, ARM, LOCKED, STOPPED.
- **Any state, select change (highest priority):** next state is IDLE, or STOPPED if new `sel`=3. `mcnt`=0, `locked`=0, `err` unchanged.
- **IDLE:** first `rise` → ARM. This edge is a reference only; no measurement.
- **ARM, `rise` with `cnt`==`exp`:**
  - `period`=`cnt`, `meas_valid`=1, `mcnt`++.
  - If `mcnt` reaches LOCK_N → LOCKED, `locked`=1.
- **ARM, `rise` with `cnt`!=`exp` (early edge):**
  - `period`=`cnt`, `meas_valid`=1, `mcnt`=0.
  - Stay in ARM; this edge is the new reference.
- **ARM or LOCKED, no `rise` with `cnt`==`exp` (late edge, timeout):**
  - → IDLE, `mcnt`=0, `locked`=0.
  - From LOCKED, also set `err`.
- **LOCKED, matching `rise`:** `period`/`meas_valid` update; remain LOCKED.
- **LOCKED, early `rise`:**
  - `err`=1, `locked`=0, `mcnt`=0 → ARM.
  - `period`/`meas_valid` update.
- **STOPPED:** `locked`=0. Any `rise` sets `err`. No `period` update.
- **`err`:** cleared by `err_clr`. If a set condition occurs in the same cycle, set wins.
- **Saturation:** `cnt` saturation never produces a match; the timeout fires before it.
- **Rule:** `exp` ≤ 2^CNT_W-1.

## Timing
- **Reset values:** all outputs, `cnt`, `mcnt`, `div_q`, `sel_q` = 0. State = IDLE.
- **Register inputs:** `rise`, `cnt`, and select change are evaluated in the cycle where `div_in`=1 and `div_q`=0. All outputs are registered and become visible on the next `clk` edge, i.e. 1-cycle latency from the sampled `div_in` high.
- **`meas_valid`:** exactly one cycle per measured edge.
- **Lock latency:** from the IDLE reference edge, `locked` rises 1 cycle after the LOCK_N-th matching edge. For `sel`=0 that is 2·LOCK_N cycles after the reference edge, plus 1.
- **Timeout detection:** in the cycle where `cnt`==`exp` without `rise`, i.e. one cycle after the edge was due.
- **`rst` mid-operation:** returns to reset values on the next edge regardless of state. `err` is cleared.

## Structure
- **Package `clkmon_pkg`:**
  - state enum (IDLE, ARM, LOCKED, STOPPED);
  - `sel` encoding constants;
  - function `exp_period(sel)` returning the expected period, 0 for `sel`=3.
- **Sub-module `clkmon_edge_det`:** registers `div_in` and outputs `rise`. Trivial but reused by other monitors.
- **Top level:** counters, FSM, and outputs.
- **Size:** ~150–250 lines total.

## Test plan
- **Lock at /2:** `rst` high 3 cycles, `sel`=0, `div_in` toggles every cycle → `locked`=1 one cycle after the 5th rise. `period`=2 with a `meas_valid` pulse on rises 2–5 and after. `err`=0.
- **Stopped edge:** `sel` 0→2 while locked → `locked`=0 next cycle, `err` stays 0. Then a /8 waveform → relock after LOCK_N matching edges with `period`=8. Then `sel`=3 with one `div_in` pulse → `err`=1.
- **Early edge while locked:** `sel`=1 locked, one period shortened to 3 cycles → `meas_valid`, `period`=3, `err`=1, `locked`=0. Four further 4-cycle periods → `locked`=1, `err` still 1.
- **Late edge (timeout):** `sel`=1 locked, `div_in` stuck low → `err`=1 and `locked`=0 in the cycle after `cnt` reaches 4. State is IDLE; the next rise produces no `meas_valid`.
- **Clear/set collision:** `err_clr` asserted in the same cycle as a new error → `err` stays 1. `err_clr` alone → `err`=0 next cycle.
- **Reset mid-measurement:** `rst` pulsed mid-period while LOCKED → all outputs 0 the next cycle; lock sequence restarts from IDLE.
